// File: rtl/mem_lat_val_rdy.sv
// Two-port test memory (instruction + data) with val/rdy channels, fixed response
// latency and bounded per-port in-flight buffering; preload port has top priority.

module mem_lat_val_rdy_port #(
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_block,
  input  logic        i_req_val,
  output logic        o_req_rdy,
  output logic        o_acc,
  input  logic [31:0] i_rdata,
  output logic        o_resp_val,
  input  logic        i_resp_rdy,
  output logic [31:0] o_resp_data
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [CW-1:0]                 r_inflight, r_count;
  logic [PW-1:0]                 r_wr_ptr, r_rd_ptr;
  logic [QUEUE_DEPTH-1:0][31:0]  r_fifo;
  logic                          w_push, w_pop;
  logic [31:0]                   w_push_data;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Gated by rst so nothing is offered while reset is held.
  assign o_req_rdy   = rst && !i_block && (r_inflight < CW'(QUEUE_DEPTH));
  assign o_acc       = i_req_val && o_req_rdy;
  assign o_resp_val  = (r_count != '0);
  assign w_pop       = o_resp_val && i_resp_rdy;
  assign o_resp_data = o_resp_val ? r_fifo[r_rd_ptr] : '0;

  // The FIFO write is the final latency stage, so only LATENCY-1 registers precede it.
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign w_push      = o_acc;
      assign w_push_data = i_rdata;
    end else begin : g_pipe
      logic [LATENCY-1:1]       r_vld_pipe;
      logic [LATENCY-1:1][31:0] r_dat_pipe;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_vld_pipe <= '0;
        else begin
          r_vld_pipe[1] <= o_acc;
          for (int s = 2; s < LATENCY; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
      end

      always_ff @(posedge clk) begin
        r_dat_pipe[1] <= i_rdata;
        for (int s = 2; s < LATENCY; s++) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end

      assign w_push      = r_vld_pipe[LATENCY-1];
      assign w_push_data = r_dat_pipe[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      case ({o_acc, w_pop})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
    end
  end

  // Inflight bounds pipeline + FIFO occupancy, so a push can never overflow.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end
endmodule

module mem_lat_val_rdy #(
  parameter int NUM_WORDS   = 256,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_en,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,
  output logic [31:0] imemresp_data,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,
  output logic [31:0] dmemresp_rdata
);
  localparam int AW = $clog2(NUM_WORDS);

  logic [31:0]      r_mem [NUM_WORDS];
  logic [AW-1:0]    w_init_idx, w_iidx, w_didx;
  logic [1:0]       w_req_val, w_req_rdy, w_acc, w_resp_val, w_resp_rdy;
  logic [1:0][31:0] w_rdata, w_resp_data;
  logic             w_unused;

  assign w_init_idx = init_addr[2 +: AW];
  assign w_iidx     = imemreq_addr[2 +: AW];
  assign w_didx     = dmemreq_addr[2 +: AW];
  assign w_unused   = ^{init_addr[1:0], init_addr[31:AW+2], imemreq_addr[1:0],
                        imemreq_addr[31:AW+2], dmemreq_addr[1:0], dmemreq_addr[31:AW+2]};

  // Port 0 = instruction, port 1 = data. Reads sample the array before this edge's write.
  assign w_req_val  = {dmemreq_val, imemreq_val};
  assign w_resp_rdy = {dmemresp_rdy, imemresp_rdy};
  assign w_rdata[0] = r_mem[w_iidx];
  assign w_rdata[1] = dmemreq_type ? 32'h0 : r_mem[w_didx];

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      mem_lat_val_rdy_port #(
        .LATENCY     (LATENCY),
        .QUEUE_DEPTH (QUEUE_DEPTH)
      ) u_port (
        .clk         (clk),
        .rst         (rst),
        .i_block     (init_en),
        .i_req_val   (w_req_val[p]),
        .o_req_rdy   (w_req_rdy[p]),
        .o_acc       (w_acc[p]),
        .i_rdata     (w_rdata[p]),
        .o_resp_val  (w_resp_val[p]),
        .i_resp_rdy  (w_resp_rdy[p]),
        .o_resp_data (w_resp_data[p])
      );
    end
  endgenerate

  assign imemreq_rdy    = w_req_rdy[0];
  assign dmemreq_rdy    = w_req_rdy[1];
  assign imemresp_val   = w_resp_val[0];
  assign dmemresp_val   = w_resp_val[1];
  assign imemresp_data  = w_resp_data[0];
  assign dmemresp_rdata = w_resp_data[1];

  always_ff @(posedge clk) begin
    if (init_en)                     r_mem[w_init_idx] <= init_data;
    else if (w_acc[1] && dmemreq_type) r_mem[w_didx]   <= dmemreq_wdata;
  end
endmodule

// File: tb/tb_mem_lat_val_rdy.sv
// Directed bench for mem_lat_val_rdy: table of single transactions plus hand
// sequences for back-to-back, backpressure, same-edge conflict and mid-flight reset.
module tb_mem_lat_val_rdy;
  logic        clk = 1'b0;
  logic        rst;
  logic        init_en;
  logic [31:0] init_addr, init_data;
  logic        imemreq_val, imemreq_rdy, imemresp_val, imemresp_rdy;
  logic [31:0] imemreq_addr, imemresp_data;
  logic        dmemreq_val, dmemreq_rdy, dmemreq_type, dmemresp_val, dmemresp_rdy;
  logic [31:0] dmemreq_addr, dmemreq_wdata, dmemresp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        port;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  mem_lat_val_rdy #(.NUM_WORDS(256), .LATENCY(2), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy), .dmemresp_rdata(dmemresp_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic init_w(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    init_en = 1'b1; init_addr = a; init_data = d;
    #1;
    chk("init_blocks_rdy", {30'd0, imemreq_rdy, dmemreq_rdy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    init_en = 1'b0;
  endtask

  // One transaction with resp_rdy high: not visible after acceptance edge, visible after the next.
  task automatic do_req(input vec_t v, input string tag);
    @(negedge clk);
    if (!v.port) begin
      imemreq_val = 1'b1; imemreq_addr = v.addr;
    end else begin
      dmemreq_val = 1'b1; dmemreq_type = v.typ; dmemreq_addr = v.addr; dmemreq_wdata = v.wdata;
    end
    #1;
    chk({tag, "_rdy"}, {31'd0, v.port ? dmemreq_rdy : imemreq_rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    chk({tag, "_early"}, {31'd0, v.port ? dmemresp_val : imemresp_val}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_val"}, {31'd0, v.port ? dmemresp_val : imemresp_val}, 32'd1);
    chk({tag, "_data"}, v.port ? dmemresp_rdata : imemresp_data, v.exp);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   n_acc;
    logic seen;
    vec_t v;

    rst = 1'b0; init_en = 1'b0; init_addr = '0; init_data = '0;
    imemreq_val = 1'b0; imemreq_addr = '0; imemresp_rdy = 1'b1;
    dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
    dmemresp_rdy = 1'b1;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,  32'h1234_5678};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,  32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0400, 32'hAA, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,  32'hAA};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0,  32'hAA};
    vecs[5]  = '{1'b0, 1'b0, 32'h0000_0102, 32'h0,  32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FC20, 32'h0,  32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_03FC, 32'h55, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_07FC, 32'h0,  32'h55};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0404, 32'h77, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0,  32'h77};

    // Reset state
    @(negedge clk);
    chk("rst_rdy",   {30'd0, imemreq_rdy, dmemreq_rdy}, 32'd0);
    chk("rst_val",   {30'd0, imemresp_val, dmemresp_val}, 32'd0);
    chk("rst_idata", imemresp_data, 32'd0);
    chk("rst_ddata", dmemresp_rdata, 32'd0);
    rst = 1'b1;

    init_w(32'h100, 32'h1234_5678);
    init_w(32'h040, 32'h1);
    for (int i = 0; i < 4; i++) init_w(32'h200 + 4 * i, 32'hA0 + i);

    // Back-to-back dmem write then read of the same word
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h20; dmemreq_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    dmemreq_type = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dmemreq_val = 1'b0;
    chk("b2b_wr_val",  {31'd0, dmemresp_val}, 32'd1);
    chk("b2b_wr_data", dmemresp_rdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rd_val",  {31'd0, dmemresp_val}, 32'd1);
    chk("b2b_rd_data", dmemresp_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle", {31'd0, dmemresp_val}, 32'd0);

    for (int i = 0; i < 11; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: imem responses stalled, requests every cycle
    @(negedge clk);
    imemresp_rdy = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      imemreq_val = 1'b1; imemreq_addr = 32'h200 + 4 * n_acc;
      #1;
      chk($sformatf("bp_rdy%0d", i), {31'd0, imemreq_rdy}, (i < 4) ? 32'd1 : 32'd0);
      if (imemreq_rdy) n_acc++;
      @(posedge clk);
      @(negedge clk);
    end
    imemreq_val = 1'b0;
    chk("bp_accepted", n_acc, 32'd4);
    chk("bp_hold_val",  {31'd0, imemresp_val}, 32'd1);
    chk("bp_hold_data", imemresp_data, 32'hA0);
    imemresp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain%0d_val", k), {31'd0, imemresp_val}, 32'd1);
      chk($sformatf("bp_drain%0d_data", k), imemresp_data, 32'hA0 + k);
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_empty", {31'd0, imemresp_val}, 32'd0);
    chk("bp_rdy_back", {31'd0, imemreq_rdy}, 32'd1);

    // Same-edge imem read / dmem write to one word
    imemreq_val = 1'b1; imemreq_addr = 32'h40;
    dmemreq_val = 1'b1; dmemreq_type = 1'b1; dmemreq_addr = 32'h40; dmemreq_wdata = 32'h2;
    @(posedge clk);
    @(negedge clk);
    imemreq_val = 1'b0; dmemreq_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("same_i_val",  {31'd0, imemresp_val}, 32'd1);
    chk("same_i_data", imemresp_data, 32'h1);
    chk("same_d_val",  {31'd0, dmemresp_val}, 32'd1);
    chk("same_d_data", dmemresp_rdata, 32'h0);
    @(posedge clk);
    v = '{1'b0, 1'b0, 32'h40, 32'h0, 32'h2};
    do_req(v, "same_after");

    // Reset with three reads in flight
    @(negedge clk);
    imemresp_rdy = 1'b0;
    imemreq_val = 1'b1; imemreq_addr = 32'h100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    imemreq_val = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_rdy",   {30'd0, imemreq_rdy, dmemreq_rdy}, 32'd0);
    chk("mrst_val",   {30'd0, imemresp_val, dmemresp_val}, 32'd0);
    chk("mrst_idata", imemresp_data, 32'd0);
    imemresp_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_rdy_release", {31'd0, imemreq_rdy}, 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (imemresp_val) seen = 1'b1;
    end
    chk("mrst_no_resp", {31'd0, seen}, 32'd0);
    v = '{1'b0, 1'b0, 32'h100, 32'h0, 32'h1234_5678};
    do_req(v, "mrst_keep_i");
    v = '{1'b1, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF};
    do_req(v, "mrst_keep_d");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
